// File: rtl/on_off_channel_gate.sv
// ============================================================================
// Module      : on_off_channel_gate
// Description : Frame-aligned per-channel mute gate with post-unmute guard.
//               Optional macro ON_OFF_BLANK_CNT_EN adds blanked-sample counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module on_off_channel_gate #(
  parameter int N_CH       = 4,
  parameter int DATA_W     = 16,
  parameter int GUARD_LEN  = 8,
  parameter int GUARD_W    = 16,
  parameter bit INIT_MUTED = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_CH*DATA_W-1:0]   data_in,
  input  logic                     valid_in,
  input  logic                     sof_in,
  input  logic [N_CH-1:0]          mode,
  output logic [N_CH*DATA_W-1:0]   data_out,
  output logic                     valid_out,
  output logic                     sof_out,
  output logic [N_CH-1:0]          muted
`ifdef ON_OFF_BLANK_CNT_EN
  ,
  input  logic                     blank_clr,
  output logic [N_CH*16-1:0]       blank_cnt
`endif
);

  localparam logic [1:0] c_pass  = 2'd0;
  localparam logic [1:0] c_muted = 2'd1;
  localparam logic [1:0] c_guard = 2'd2;

  localparam logic [GUARD_W-1:0] c_guard_len = GUARD_W'(GUARD_LEN);
  localparam logic [1:0]         c_rst_state = INIT_MUTED ? c_muted : c_pass;

  logic w_boundary;
  logic r_valid;
  logic r_sof;

  assign w_boundary = valid_in & sof_in;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_sof   <= 1'b0;
    end else begin
      r_valid <= valid_in;
      r_sof   <= w_boundary;
    end
  end

  assign valid_out = r_valid;
  assign sof_out   = r_sof;

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    logic [1:0]         r_state;
    logic [GUARD_W-1:0] r_cnt;
    logic [DATA_W-1:0]  r_data;
    logic               r_muted;
    logic [1:0]         w_eff_state;
    logic [GUARD_W-1:0] w_eff_cnt;

    // State applied to the current sample: boundary transitions take effect
    // on the boundary sample itself.
    always_comb begin
      w_eff_state = r_state;
      w_eff_cnt   = r_cnt;
      if (w_boundary) begin
        case (r_state)
          c_pass: begin
            if (mode[k]) w_eff_state = c_muted;
          end
          c_muted: begin
            if (!mode[k]) begin
              if (c_guard_len == '0) begin
                w_eff_state = c_pass;
              end else begin
                w_eff_state = c_guard;
                w_eff_cnt   = c_guard_len;
              end
            end
          end
          c_guard: begin
            if (mode[k]) w_eff_state = c_muted;
          end
          default: w_eff_state = c_muted;
        endcase
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        r_state <= c_rst_state;
        r_cnt   <= '0;
        r_data  <= '0;
        r_muted <= INIT_MUTED;
      end else if (valid_in) begin
        r_muted <= (w_eff_state != c_pass);
        r_data  <= (w_eff_state == c_pass) ? data_in[k*DATA_W +: DATA_W] : '0;
        if (w_eff_state == c_guard) begin
          // The guard may expire mid-frame; the next sample then passes.
          r_cnt   <= w_eff_cnt - 1'b1;
          r_state <= (w_eff_cnt <= 1) ? c_pass : c_guard;
        end else begin
          r_cnt   <= w_eff_cnt;
          r_state <= w_eff_state;
        end
      end
    end

    assign data_out[k*DATA_W +: DATA_W] = r_data;
    assign muted[k]                     = r_muted;

`ifdef ON_OFF_BLANK_CNT_EN
    logic [15:0] r_blank_cnt;

    always_ff @(posedge clk) begin
      if (rst || blank_clr) begin
        r_blank_cnt <= '0;
      end else if (valid_in && (w_eff_state != c_pass) && (r_blank_cnt != 16'hFFFF)) begin
        r_blank_cnt <= r_blank_cnt + 16'd1;
      end
    end

    assign blank_cnt[k*16 +: 16] = r_blank_cnt;
`endif
  end : g_ch

endmodule

`default_nettype wire

// File: tb/tb_on_off_channel_gate.sv
// ============================================================================
// Module      : tb_on_off_channel_gate
// Description : Directed bench for on_off_channel_gate (GUARD_LEN=3), with a
//               second instance reset into PASS.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_on_off_channel_gate;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rst0 = 1'b1;
  logic [63:0] data_in = '0;
  logic        valid_in = 1'b0;
  logic        sof_in = 1'b0;
  logic [3:0]  mode = 4'b1111;
  logic [63:0] dout, dout0;
  logic        vout, vout0, sout, sout0;
  logic [3:0]  muted, muted0;
`ifdef ON_OFF_BLANK_CNT_EN
  logic        blank_clr = 1'b0;
  logic [63:0] blank_cnt, blank_cnt0;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  on_off_channel_gate #(
    .N_CH(4), .DATA_W(16), .GUARD_LEN(3), .GUARD_W(16), .INIT_MUTED(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .valid_in(valid_in),
    .sof_in(sof_in), .mode(mode), .data_out(dout), .valid_out(vout),
    .sof_out(sout), .muted(muted)
`ifdef ON_OFF_BLANK_CNT_EN
    , .blank_clr(blank_clr), .blank_cnt(blank_cnt)
`endif
  );

  on_off_channel_gate #(
    .N_CH(4), .DATA_W(16), .GUARD_LEN(3), .GUARD_W(16), .INIT_MUTED(1'b0)
  ) dut0 (
    .clk(clk), .rst(rst0), .data_in(data_in), .valid_in(valid_in),
    .sof_in(sof_in), .mode(mode), .data_out(dout0), .valid_out(vout0),
    .sof_out(sout0), .muted(muted0)
`ifdef ON_OFF_BLANK_CNT_EN
    , .blank_clr(blank_clr), .blank_cnt(blank_cnt0)
`endif
  );

  function automatic logic [63:0] pack(input int n);
    logic [63:0] p;
    for (int k = 0; k < 4; k++) p[k*16 +: 16] = 16'(32'h1000 + 16 * n + k);
    return p;
  endfunction

  function automatic logic [63:0] zmask(input logic [63:0] v, input logic [3:0] z);
    logic [63:0] r;
    r = v;
    for (int k = 0; k < 4; k++) if (z[k]) r[k*16 +: 16] = 16'h0000;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; rst0 = 1'b1; valid_in = 1'b1; sof_in = 1'b1; mode = 4'b0000;
    data_in = pack(9);
    tick(); tick();
    vectors++;
    if (dout !== 64'h0) begin miscompares++; $display("FAIL reset_data got %h want 0", dout); end
    vectors++;
    if (vout !== 1'b0 || sout !== 1'b0) begin
      miscompares++; $display("FAIL reset_strobes got v=%b s=%b want 0/0", vout, sout);
    end
    vectors++;
    if (muted !== 4'b1111) begin miscompares++; $display("FAIL reset_muted got %b want 1111", muted); end
    vectors++;
    if (muted0 !== 4'b0000 || dout0 !== 64'h0) begin
      miscompares++; $display("FAIL reset_init_pass got muted=%b data=%h want 0000/0", muted0, dout0);
    end
    rst = 1'b0; rst0 = 1'b0; valid_in = 1'b0; sof_in = 1'b0; mode = 4'b1111;
    tick();
  endtask

  task automatic test_unmute();
    logic [63:0] exp;
    mode = 4'b0000;
    for (int n = 0; n < 8; n++) begin
      data_in = pack(n); valid_in = 1'b1; sof_in = (n == 0);
      tick();
      exp = (n < 3) ? 64'h0 : pack(n);
      vectors++;
      if (dout !== exp) begin miscompares++; $display("FAIL unmute_data n=%0d got %h want %h", n, dout, exp); end
      vectors++;
      if (muted !== ((n < 3) ? 4'b1111 : 4'b0000)) begin
        miscompares++; $display("FAIL unmute_muted n=%0d got %b", n, muted);
      end
      vectors++;
      if (vout !== 1'b1 || sout !== 1'(n == 0)) begin
        miscompares++; $display("FAIL unmute_strobes n=%0d got v=%b s=%b", n, vout, sout);
      end
      vectors++;
      if (dout0 !== pack(n)) begin miscompares++; $display("FAIL init_pass_data n=%0d got %h want %h", n, dout0, pack(n)); end
    end
    valid_in = 1'b0; sof_in = 1'b0; data_in = '1;
    tick();
    vectors++;
    if (vout !== 1'b0 || dout !== pack(7)) begin
      miscompares++; $display("FAIL unmute_idle got v=%b data=%h want 0/%h", vout, dout, pack(7));
    end
  endtask

  task automatic test_mid_frame();
    for (int n = 0; n < 8; n++) begin
      data_in = pack(n); valid_in = 1'b1; sof_in = (n == 0);
      mode = (n >= 5) ? 4'b0010 : 4'b0000;
      tick();
      vectors++;
      if (dout !== pack(n) || muted !== 4'b0000) begin
        miscompares++; $display("FAIL midframe_pass n=%0d got %h/%b want %h/0000", n, dout, muted, pack(n));
      end
    end
    for (int n = 0; n < 2; n++) begin
      data_in = pack(n); sof_in = (n == 0); mode = 4'b0010;
      tick();
      vectors++;
      if (dout !== zmask(pack(n), 4'b0010) || muted !== 4'b0010) begin
        miscompares++;
        $display("FAIL midframe_mute n=%0d got %h/%b want %h/0010", n, dout, muted, zmask(pack(n), 4'b0010));
      end
    end
  endtask

  task automatic test_valid_gaps();
    logic [63:0] exp;
    logic [3:0]  expm;
    for (int n = 0; n < 4; n++) begin
      data_in = pack(n); valid_in = 1'b1; sof_in = (n == 0); mode = 4'b0000;
      tick();
      exp  = (n < 3) ? zmask(pack(n), 4'b0010) : pack(n);
      expm = (n < 3) ? 4'b0010 : 4'b0000;
      vectors++;
      if (dout !== exp || muted !== expm) begin
        miscompares++; $display("FAIL gap_sample n=%0d got %h/%b want %h/%b", n, dout, muted, exp, expm);
      end
      if (n < 3) begin
        // Idle cycles with sof and mode asserted must not count as boundaries.
        valid_in = 1'b0; sof_in = 1'b1; mode = 4'b1111; data_in = '1;
        for (int g = 0; g < 10; g++) begin
          tick();
          vectors++;
          if (dout !== exp || vout !== 1'b0 || sout !== 1'b0 || muted !== expm) begin
            miscompares++;
            $display("FAIL gap_hold n=%0d g=%0d got %h v=%b s=%b m=%b want %h", n, g, dout, vout, sout, muted, exp);
          end
        end
      end
    end
  endtask

  task automatic test_guard_abort();
    int         tn[9] = '{0, 1, 0, 0, 1, 0, 1, 2, 3};
    logic       ts[9] = '{1, 0, 1, 1, 0, 1, 0, 0, 0};
    logic [3:0] tm[9] = '{4'b0100, 4'b0000, 4'b0000, 4'b0100, 4'b0000,
                          4'b0000, 4'b0000, 4'b0000, 4'b0000};
    logic [3:0] tz[9] = '{4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0100,
                          4'b0100, 4'b0100, 4'b0100, 4'b0000};
    for (int i = 0; i < 9; i++) begin
      data_in = pack(tn[i]); valid_in = 1'b1; sof_in = ts[i]; mode = tm[i];
      tick();
      vectors++;
      if (dout !== zmask(pack(tn[i]), tz[i]) || muted !== tz[i]) begin
        miscompares++;
        $display("FAIL guard_abort step=%0d got %h/%b want %h/%b", i, dout, muted, zmask(pack(tn[i]), tz[i]), tz[i]);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    mode = 4'b0000; valid_in = 1'b1;
    data_in = pack(0); sof_in = 1'b1; tick();
    data_in = pack(1); sof_in = 1'b0; tick();
    rst = 1'b1; rst0 = 1'b1; data_in = pack(2);
    tick();
    vectors++;
    if (dout !== 64'h0 || muted !== 4'b1111 || vout !== 1'b0 || sout !== 1'b0) begin
      miscompares++; $display("FAIL rst_mid got %h/%b v=%b want 0/1111 v=0", dout, muted, vout);
    end
    vectors++;
    if (dout0 !== 64'h0 || muted0 !== 4'b0000) begin
      miscompares++; $display("FAIL rst_mid_pass got %h/%b want 0/0000", dout0, muted0);
    end
`ifdef ON_OFF_BLANK_CNT_EN
    vectors++;
    if (blank_cnt !== 64'h0) begin miscompares++; $display("FAIL blank_rst got %h want 0", blank_cnt); end
`endif
    rst = 1'b0; rst0 = 1'b0;
    data_in = pack(2); sof_in = 1'b0;
    tick();
    vectors++;
    if (dout !== 64'h0 || muted !== 4'b1111) begin
      miscompares++; $display("FAIL post_rst_muted got %h/%b want 0/1111", dout, muted);
    end
    vectors++;
    if (dout0 !== pack(2) || muted0 !== 4'b0000) begin
      miscompares++; $display("FAIL post_rst_pass got %h/%b want %h/0000", dout0, muted0, pack(2));
    end
`ifdef ON_OFF_BLANK_CNT_EN
    vectors++;
    if (blank_cnt !== {4{16'd1}} || blank_cnt0 !== 64'h0) begin
      miscompares++; $display("FAIL blank_inc got %h/%h want 0001x4/0", blank_cnt, blank_cnt0);
    end
    blank_clr = 1'b1;
`endif
    data_in = pack(0); sof_in = 1'b1;
    tick();
    vectors++;
    if (dout !== 64'h0 || muted !== 4'b1111 || dout0 !== pack(0)) begin
      miscompares++; $display("FAIL post_rst_guard got %h/%b pass=%h", dout, muted, dout0);
    end
`ifdef ON_OFF_BLANK_CNT_EN
    vectors++;
    if (blank_cnt !== 64'h0) begin miscompares++; $display("FAIL blank_clr got %h want 0", blank_cnt); end
    blank_clr = 1'b0;
    data_in = pack(1); sof_in = 1'b0;
    tick();
    vectors++;
    if (blank_cnt !== {4{16'd1}}) begin miscompares++; $display("FAIL blank_after_clr got %h want 0001x4", blank_cnt); end
`endif
    valid_in = 1'b0; sof_in = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_unmute();
    test_mid_frame();
    test_valid_gaps();
    test_guard_abort();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
